// File: rtl/bp_resolve_ctrl.sv
// bp_resolve_ctrl: carries IF-time BTB prediction metadata to EX, resolves it against the
// actual outcome and issues one registered BTB update, redirect and statistics per branch.
module bp_resolve_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_id_xfer_i,
    input  logic             bp_hit_i,
    input  logic [1:0]       bp_cnt_i,
    input  logic [31:0]      bp_target_i,
    input  logic             kill_id_i,
    input  logic             id_ex_xfer_i,
    input  logic             ex_ready_i,
    input  logic             ex_branch_valid_i,
    input  logic             ex_taken_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_compressed_i,
    output logic [1:0]       cache_operation_o,
    output logic [31:0]      pc_ex_o,
    output logic [31:0]      target_pc_ex_o,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);
    localparam logic [1:0] NOP = 2'd0, INCREMENT = 2'd1, DECREMENT = 2'd2, NEW_ENTRY = 2'd3;
    logic        id_valid, id_hit, ex_valid, ex_hit, done;
    logic [1:0]  id_cnt, ex_cnt, cmd;
    logic [31:0] id_target, ex_target, redirect_pc;
    logic        resolve, hit, pred_taken, tgt_match, mispredict;
    // A branch whose metadata was flushed still resolves, as a BTB miss
    always_comb begin
        resolve     = ex_branch_valid_i & ~done;
        hit         = ex_valid & ex_hit;
        pred_taken  = hit & ex_cnt[1];
        tgt_match   = ex_target == ex_target_i;
        mispredict  = (pred_taken != ex_taken_i) | (pred_taken & ex_taken_i & ~tgt_match);
        cmd         = !hit ? (ex_taken_i ? NEW_ENTRY : NOP) :
                      !ex_taken_i ? DECREMENT : tgt_match ? INCREMENT : NEW_ENTRY;
        redirect_pc = ex_taken_i ? ex_target_i : ex_pc_i + (ex_compressed_i ? 32'd2 : 32'd4);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid  <= 1'b0;
            id_hit    <= 1'b0;
            id_cnt    <= 2'd0;
            id_target <= 32'd0;
            ex_valid  <= 1'b0;
            ex_hit    <= 1'b0;
            ex_cnt    <= 2'd0;
            ex_target <= 32'd0;
            done      <= 1'b0;
        end else begin
            id_valid <= kill_id_i ? 1'b0 : if_id_xfer_i ? 1'b1 : id_ex_xfer_i ? 1'b0 : id_valid;
            if (if_id_xfer_i) begin
                id_hit    <= bp_hit_i;
                id_cnt    <= bp_cnt_i;
                id_target <= bp_target_i;
            end
            if (id_ex_xfer_i) begin
                ex_valid  <= id_valid;
                ex_hit    <= id_hit;
                ex_cnt    <= id_cnt;
                ex_target <= id_target;
            end else if (ex_ready_i) begin
                ex_valid  <= 1'b0;
            end
            done <= ex_ready_i ? 1'b0 : resolve ? 1'b1 : done;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_operation_o <= NOP;
            pc_ex_o           <= 32'd0;
            target_pc_ex_o    <= 32'd0;
            mispredict_o      <= 1'b0;
            redirect_pc_o     <= 32'd0;
            branch_cnt_o      <= '0;
            mispredict_cnt_o  <= '0;
        end else begin
            cache_operation_o <= resolve ? cmd : NOP;
            mispredict_o      <= resolve & mispredict;
            if (resolve && cmd != NOP) begin
                pc_ex_o        <= ex_pc_i;
                target_pc_ex_o <= ex_target_i;
            end
            if (resolve & mispredict) begin
                redirect_pc_o    <= redirect_pc;
                mispredict_cnt_o <= mispredict_cnt_o + {{(CNT_W-1){1'b0}}, ~&mispredict_cnt_o};
            end
            if (resolve)
                branch_cnt_o <= branch_cnt_o + {{(CNT_W-1){1'b0}}, ~&branch_cnt_o};
        end
    end
endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// tb_bp_resolve_ctrl: scoreboard bench for bp_resolve_ctrl (counters narrowed to 4 bits).
module tb_bp_resolve_ctrl;
    localparam int CNT_W = 4;
    localparam logic [1:0] NOP = 2'd0, INCREMENT = 2'd1, DECREMENT = 2'd2, NEW_ENTRY = 2'd3;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] rpc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int n_tests = 0;
    int n_fail = 0;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_id_xfer_i, bp_hit_i, kill_id_i, id_ex_xfer_i, ex_ready_i, ex_branch_valid_i;
    logic ex_taken_i, ex_compressed_i;
    logic [1:0] bp_cnt_i;
    logic [31:0] bp_target_i, ex_pc_i, ex_target_i;
    logic [1:0] cache_operation_o;
    logic [31:0] pc_ex_o, target_pc_ex_o, redirect_pc_o;
    logic mispredict_o;
    logic [CNT_W-1:0] branch_cnt_o, mispredict_cnt_o;

    bp_resolve_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_xfer_i(if_id_xfer_i), .bp_hit_i(bp_hit_i), .bp_cnt_i(bp_cnt_i),
        .bp_target_i(bp_target_i), .kill_id_i(kill_id_i), .id_ex_xfer_i(id_ex_xfer_i),
        .ex_ready_i(ex_ready_i), .ex_branch_valid_i(ex_branch_valid_i), .ex_taken_i(ex_taken_i),
        .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i), .ex_compressed_i(ex_compressed_i),
        .cache_operation_o(cache_operation_o), .pc_ex_o(pc_ex_o), .target_pc_ex_o(target_pc_ex_o),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        if_id_xfer_i = 0; bp_hit_i = 0; bp_cnt_i = 0; bp_target_i = 0; kill_id_i = 0;
        id_ex_xfer_i = 0; ex_ready_i = 0; ex_branch_valid_i = 0; ex_taken_i = 0;
        ex_pc_i = 0; ex_target_i = 0; ex_compressed_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic mis, input logic [31:0] rpc);
        exp_t x;
        x = '{op, pc, tgt, mis, rpc};
        sb.push_back(x);
    endtask

    task automatic load_if(input logic h, input logic [1:0] c, input logic [31:0] t);
        if_id_xfer_i = 1; bp_hit_i = h; bp_cnt_i = c; bp_target_i = t;
    endtask

    task automatic set_ex(input logic tk, input logic [31:0] pc, input logic [31:0] t, input logic cmp);
        ex_branch_valid_i = 1; ex_ready_i = 1; ex_taken_i = tk;
        ex_pc_i = pc; ex_target_i = t; ex_compressed_i = cmp;
    endtask

    // IF load, ID->EX move, then resolve; returns 1 ns after the resolving edge
    task automatic branch(input logic h, input logic [1:0] c, input logic [31:0] pt, input logic tk,
                          input logic [31:0] pc, input logic [31:0] t, input logic cmp);
        @(negedge clk); load_if(h, c, pt);
        @(negedge clk); if_id_xfer_i = 0; id_ex_xfer_i = 1;
        @(negedge clk); id_ex_xfer_i = 0; set_ex(tk, pc, t, cmp);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (cache_operation_o !== NOP || mispredict_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cmd op=%0d mis=%b expected op=0 mis=0", cache_operation_o, mispredict_o);
        end
        n_tests++;
        if (pc_ex_o !== 32'd0 || target_pc_ex_o !== 32'd0 || redirect_pc_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_pcs pc=%h tgt=%h rpc=%h expected all 0", pc_ex_o, target_pc_ex_o, redirect_pc_o);
        end
        n_tests++;
        if (branch_cnt_o !== 4'd0 || mispredict_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt br=%0d mis=%0d expected 0 0", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    task automatic test_miss_taken();
        do_reset();
        push(NEW_ENTRY, 32'h100, 32'h80, 1'b1, 32'h80);
        branch(1'b0, 2'd0, 32'h0, 1'b1, 32'h100, 32'h80, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (cache_operation_o !== e.op || pc_ex_o !== e.pc || target_pc_ex_o !== e.tgt ||
            mispredict_o !== e.mis || redirect_pc_o !== e.rpc) begin
            n_fail++;
            $display("FAIL miss_taken got op=%0d pc=%h tgt=%h mis=%b rpc=%h expected op=%0d pc=%h tgt=%h mis=%b rpc=%h",
                     cache_operation_o, pc_ex_o, target_pc_ex_o, mispredict_o, redirect_pc_o, e.op, e.pc, e.tgt, e.mis, e.rpc);
        end
        n_tests++;
        if (branch_cnt_o !== 4'd1 || mispredict_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL miss_taken_cnt br=%0d mis=%0d expected 1 1", branch_cnt_o, mispredict_cnt_o);
        end
        @(posedge clk); #1;
        n_tests++;
        if (cache_operation_o !== NOP || mispredict_o !== 1'b0 || pc_ex_o !== 32'h100 || target_pc_ex_o !== 32'h80) begin
            n_fail++;
            $display("FAIL cmd_return_nop op=%0d mis=%b pc=%h tgt=%h expected op=0 mis=0 pc=100 tgt=80",
                     cache_operation_o, mispredict_o, pc_ex_o, target_pc_ex_o);
        end
    endtask

    task automatic test_hit_direction();
        do_reset();
        push(INCREMENT, 32'h100, 32'h80, 1'b0, 32'h0);
        push(DECREMENT, 32'h100, 32'h80, 1'b1, 32'h104);
        push(DECREMENT, 32'h100, 32'h80, 1'b1, 32'h102);
        for (int i = 0; i < 3; i++) begin
            branch(1'b1, 2'd3, 32'h80, i == 0, 32'h100, 32'h80, i == 2);
            e = sb.pop_front();
            n_tests++;
            if (cache_operation_o !== e.op || pc_ex_o !== e.pc || target_pc_ex_o !== e.tgt ||
                mispredict_o !== e.mis || (e.mis && redirect_pc_o !== e.rpc)) begin
                n_fail++;
                $display("FAIL hit_dir_%0d got op=%0d pc=%h tgt=%h mis=%b rpc=%h expected op=%0d pc=%h tgt=%h mis=%b rpc=%h",
                         i, cache_operation_o, pc_ex_o, target_pc_ex_o, mispredict_o, redirect_pc_o, e.op, e.pc, e.tgt, e.mis, e.rpc);
            end
        end
        n_tests++;
        if (branch_cnt_o !== 4'd3 || mispredict_cnt_o !== 4'd2) begin
            n_fail++;
            $display("FAIL hit_dir_cnt br=%0d mis=%0d expected 3 2", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    task automatic test_target_change();
        do_reset();
        push(NEW_ENTRY, 32'h100, 32'h200, 1'b1, 32'h200);
        push(NOP, 32'h100, 32'h200, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            if (i == 0) branch(1'b1, 2'd2, 32'h80, 1'b1, 32'h100, 32'h200, 1'b0);
            else        branch(1'b0, 2'd0, 32'h0, 1'b0, 32'h700, 32'h40, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (cache_operation_o !== e.op || pc_ex_o !== e.pc || target_pc_ex_o !== e.tgt ||
                mispredict_o !== e.mis || (e.mis && redirect_pc_o !== e.rpc)) begin
                n_fail++;
                $display("FAIL tgt_change_%0d got op=%0d pc=%h tgt=%h mis=%b rpc=%h expected op=%0d pc=%h tgt=%h mis=%b rpc=%h",
                         i, cache_operation_o, pc_ex_o, target_pc_ex_o, mispredict_o, redirect_pc_o, e.op, e.pc, e.tgt, e.mis, e.rpc);
            end
        end
        n_tests++;
        if (branch_cnt_o !== 4'd2 || mispredict_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL tgt_change_cnt br=%0d mis=%0d expected 2 1", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    task automatic test_stall();
        int cmds = 0;
        do_reset();
        push(NEW_ENTRY, 32'h180, 32'h40, 1'b1, 32'h40);
        @(negedge clk); load_if(1'b0, 2'd0, 32'h0);
        @(negedge clk); if_id_xfer_i = 0; id_ex_xfer_i = 1;
        @(negedge clk); id_ex_xfer_i = 0; set_ex(1'b1, 32'h180, 32'h40, 1'b0); ex_ready_i = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                @(negedge clk); ex_ready_i = 1;
            end
            if (i == 6) begin
                @(negedge clk); idle_inputs();
            end
            @(posedge clk); #1;
            if (cache_operation_o !== NOP) cmds++;
            if (i == 0) begin
                e = sb.pop_front();
                n_tests++;
                if (cache_operation_o !== e.op || pc_ex_o !== e.pc || target_pc_ex_o !== e.tgt || mispredict_o !== e.mis) begin
                    n_fail++;
                    $display("FAIL stall_first got op=%0d pc=%h tgt=%h mis=%b expected op=%0d pc=%h tgt=%h mis=%b",
                             cache_operation_o, pc_ex_o, target_pc_ex_o, mispredict_o, e.op, e.pc, e.tgt, e.mis);
                end
            end
        end
        n_tests++;
        if (cmds != 1 || branch_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL stall_single cmds=%0d br=%0d expected 1 1", cmds, branch_cnt_o);
        end
    endtask

    task automatic test_kill();
        do_reset();
        push(NEW_ENTRY, 32'h300, 32'h80, 1'b1, 32'h80);
        @(negedge clk); load_if(1'b1, 2'd3, 32'h80); kill_id_i = 1;
        @(negedge clk); if_id_xfer_i = 0; kill_id_i = 0; id_ex_xfer_i = 1;
        @(negedge clk); id_ex_xfer_i = 0; set_ex(1'b1, 32'h300, 32'h80, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        e = sb.pop_front();
        n_tests++;
        if (cache_operation_o !== e.op || pc_ex_o !== e.pc || target_pc_ex_o !== e.tgt ||
            mispredict_o !== e.mis || redirect_pc_o !== e.rpc) begin
            n_fail++;
            $display("FAIL kill_as_miss got op=%0d pc=%h tgt=%h mis=%b rpc=%h expected op=%0d pc=%h tgt=%h mis=%b rpc=%h",
                     cache_operation_o, pc_ex_o, target_pc_ex_o, mispredict_o, redirect_pc_o, e.op, e.pc, e.tgt, e.mis, e.rpc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(INCREMENT, 32'h400, 32'h80, 1'b0, 32'h0);
        push(NEW_ENTRY, 32'h500, 32'h600, 1'b1, 32'h600);
        @(negedge clk); load_if(1'b1, 2'd3, 32'h80);
        @(negedge clk); load_if(1'b0, 2'd0, 32'h0); id_ex_xfer_i = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); if_id_xfer_i = 0; id_ex_xfer_i = (k == 0);
            set_ex(1'b1, k == 0 ? 32'h400 : 32'h500, k == 0 ? 32'h80 : 32'h600, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (cache_operation_o !== e.op || pc_ex_o !== e.pc || target_pc_ex_o !== e.tgt ||
                mispredict_o !== e.mis || (e.mis && redirect_pc_o !== e.rpc)) begin
                n_fail++;
                $display("FAIL b2b_%0d got op=%0d pc=%h tgt=%h mis=%b rpc=%h expected op=%0d pc=%h tgt=%h mis=%b rpc=%h",
                         k, cache_operation_o, pc_ex_o, target_pc_ex_o, mispredict_o, redirect_pc_o, e.op, e.pc, e.tgt, e.mis, e.rpc);
            end
        end
        idle_inputs();
        n_tests++;
        if (branch_cnt_o !== 4'd2 || mispredict_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_cnt br=%0d mis=%0d expected 2 1", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        int cmds = 0;
        do_reset();
        push(NEW_ENTRY, 32'h100, 32'h80, 1'b1, 32'h80);
        @(negedge clk); load_if(1'b0, 2'd0, 32'h0);
        @(negedge clk); if_id_xfer_i = 0; id_ex_xfer_i = 1;
        @(negedge clk); id_ex_xfer_i = 0; load_if(1'b1, 2'd3, 32'h80); set_ex(1'b1, 32'h100, 32'h80, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        e = sb.pop_front();
        n_tests++;
        if (cache_operation_o !== e.op || pc_ex_o !== e.pc || mispredict_o !== e.mis) begin
            n_fail++;
            $display("FAIL pre_reset_cmd got op=%0d pc=%h mis=%b expected op=%0d pc=%h mis=%b",
                     cache_operation_o, pc_ex_o, mispredict_o, e.op, e.pc, e.mis);
        end
        rst_n = 0;
        #1;
        n_tests++;
        if (cache_operation_o !== NOP || pc_ex_o !== 32'd0 || target_pc_ex_o !== 32'd0 || mispredict_o !== 1'b0 ||
            redirect_pc_o !== 32'd0 || branch_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset op=%0d pc=%h tgt=%h mis=%b rpc=%h br=%0d expected all 0",
                     cache_operation_o, pc_ex_o, target_pc_ex_o, mispredict_o, redirect_pc_o, branch_cnt_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        id_ex_xfer_i = 1;
        @(posedge clk); #1;
        if (cache_operation_o !== NOP) cmds++;
        @(negedge clk); id_ex_xfer_i = 0;
        @(posedge clk); #1;
        if (cache_operation_o !== NOP) cmds++;
        n_tests++;
        if (cmds != 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet cmds=%0d expected 0", cmds);
        end
        push(NEW_ENTRY, 32'h200, 32'h80, 1'b1, 32'h80);
        @(negedge clk); set_ex(1'b1, 32'h200, 32'h80, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        e = sb.pop_front();
        n_tests++;
        if (cache_operation_o !== e.op || pc_ex_o !== e.pc || mispredict_o !== e.mis || redirect_pc_o !== e.rpc) begin
            n_fail++;
            $display("FAIL reset_drops_meta got op=%0d pc=%h mis=%b rpc=%h expected op=%0d pc=%h mis=%b rpc=%h",
                     cache_operation_o, pc_ex_o, mispredict_o, redirect_pc_o, e.op, e.pc, e.mis, e.rpc);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk); set_ex(1'b1, 32'h100, 32'h80, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 9) begin
                n_tests++;
                if (mispredict_cnt_o !== 4'd10 || branch_cnt_o !== 4'd10) begin
                    n_fail++;
                    $display("FAIL cnt_mid br=%0d mis=%0d expected 10 10", branch_cnt_o, mispredict_cnt_o);
                end
            end
        end
        idle_inputs();
        n_tests++;
        if (mispredict_cnt_o !== 4'd15 || branch_cnt_o !== 4'd15) begin
            n_fail++;
            $display("FAIL cnt_saturate br=%0d mis=%0d expected 15 15", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_miss_taken();
        test_hit_direction();
        test_target_change();
        test_stall();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
